// File: rtl/sram_pattern_gen.sv
// Data-pattern source for the SRAM self-test: walks an ordered pattern list and
// produces the per-address write/expected word, reproducible from each addr_reset.
module sram_pattern_gen #(
  parameter int          DATA_BITS    = 16,
  parameter int          ADDR_BITS    = 20,
  parameter int          NUM_PATTERNS = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pattern_reset,
  input  logic                 pattern_next,
  input  logic                 addr_reset,
  input  logic                 addr_next,
  input  logic [ADDR_BITS-1:0] addr,
  output logic [DATA_BITS-1:0] pattern,
  output logic                 pattern_done,
  output logic [2:0]           pattern_id
);

  typedef enum logic [2:0] {
    PAT_ZEROS = 3'd0,
    PAT_ONES  = 3'd1,
    PAT_AA    = 3'd2,
    PAT_55    = 3'd3,
    PAT_WALK  = 3'd4,
    PAT_ADDR  = 3'd5,
    PAT_NADDR = 3'd6,
    PAT_LFSR  = 3'd7
  } pat_e;

  localparam logic [15:0]          SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [2:0]           LAST_ID = 3'(NUM_PATTERNS - 1);
  localparam int                   REPS    = (DATA_BITS + 15) / 16;
  localparam logic [DATA_BITS-1:0] ALT_AA  = DATA_BITS'({REPS * 8{2'b10}});
  localparam logic [DATA_BITS-1:0] WALK_INIT = DATA_BITS'(1);

  logic [2:0]           pattern_id_q, pattern_id_d;
  logic [DATA_BITS-1:0] walk_q, walk_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic                 reseed;
  logic                 lfsr_fb;
  logic [DATA_BITS-1:0] addr_data;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pattern_id_d = pattern_id_q;
    if (pattern_reset) begin
      pattern_id_d = 3'd0;
    end else if (pattern_next && (pattern_id_q != LAST_ID)) begin
      pattern_id_d = pattern_id_q + 3'd1;
    end
  end

  // Any pattern change also rewinds the per-address sequence so both passes start aligned.
  assign reseed  = pattern_reset | pattern_next | addr_reset;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    walk_d = walk_q;
    lfsr_d = lfsr_q;
    if (reseed) begin
      walk_d = WALK_INIT;
      lfsr_d = SEED;
    end else if (addr_next) begin
      walk_d = {walk_q[DATA_BITS-2:0], walk_q[DATA_BITS-1]};
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_id_q <= 3'd0;
      walk_q       <= WALK_INIT;
      lfsr_q       <= SEED;
    end else begin
      pattern_id_q <= pattern_id_d;
      walk_q       <= walk_d;
      lfsr_q       <= lfsr_d;
    end
  end

  // Size cast zero-extends a narrow address or keeps the low bits of a wide one.
  assign addr_data = DATA_BITS'(addr);

  always_comb begin
    pattern = '0;
    unique case (pat_e'(pattern_id_q))
      PAT_ZEROS: pattern = '0;
      PAT_ONES:  pattern = '1;
      PAT_AA:    pattern = ALT_AA;
      PAT_55:    pattern = ~ALT_AA;
      PAT_WALK:  pattern = walk_q;
      PAT_ADDR:  pattern = addr_data;
      PAT_NADDR: pattern = ~addr_data;
      PAT_LFSR:  pattern = DATA_BITS'({REPS{lfsr_q}});
      default:   pattern = '0;
    endcase
  end

  assign pattern_done = (pattern_id_q == LAST_ID);
  assign pattern_id   = pattern_id_q;

endmodule

// File: tb/tb_sram_pattern_gen.sv
// Self-checking bench for sram_pattern_gen: directed scenarios plus randomized
// strobes compared against a step-count based reference model.
module tb_sram_pattern_gen;

  localparam int DATA_BITS = 16;
  localparam int ADDR_BITS = 20;
  localparam int NP        = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 pattern_reset = 1'b0;
  logic                 pattern_next = 1'b0;
  logic                 addr_reset = 1'b0;
  logic                 addr_next = 1'b0;
  logic [ADDR_BITS-1:0] addr = '0;
  logic [DATA_BITS-1:0] pattern;
  logic                 pattern_done;
  logic [2:0]           pattern_id;
  logic [DATA_BITS-1:0] p1_pattern;
  logic                 p1_done;
  logic [2:0]           p1_id;

  sram_pattern_gen #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS), .NUM_PATTERNS(NP)) dut (
    .clk(clk), .reset(reset), .pattern_reset(pattern_reset), .pattern_next(pattern_next),
    .addr_reset(addr_reset), .addr_next(addr_next), .addr(addr),
    .pattern(pattern), .pattern_done(pattern_done), .pattern_id(pattern_id)
  );

  sram_pattern_gen #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS), .NUM_PATTERNS(1)) dut_one (
    .clk(clk), .reset(reset), .pattern_reset(pattern_reset), .pattern_next(pattern_next),
    .addr_reset(addr_reset), .addr_next(addr_next), .addr(addr),
    .pattern(p1_pattern), .pattern_done(p1_done), .pattern_id(p1_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: selected pattern index and number of addr_next steps since the last reseed.
  int m_id = 0;
  int m_k  = 0;
  logic [15:0] lfsr_tab [0:65534];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_pattern();
    logic [15:0] a16;
    a16 = addr[15:0];
    case (m_id)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'hAAAA;
      3: return 16'h5555;
      4: return 16'(32'd1 << (m_k % DATA_BITS));
      5: return a16;
      6: return ~a16;
      default: return lfsr_tab[m_k % 65535];
    endcase
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".id"},   32'(pattern_id),   32'(m_id));
    check({tag, ".done"}, 32'(pattern_done), 32'(m_id == NP - 1));
    check({tag, ".pat"},  32'(pattern),      32'(exp_pattern()));
  endtask

  // Apply one cycle of strobes, advance the model by the same rules, sample 1ns after the edge.
  task automatic step(input logic r, input logic p_r, input logic p_n, input logic a_r, input logic a_n);
    reset = r; pattern_reset = p_r; pattern_next = p_n; addr_reset = a_r; addr_next = a_n;
    @(posedge clk);
    if (r || p_r)               m_id = 0;
    else if (p_n && m_id < NP - 1) m_id = m_id + 1;
    if (r || p_r || p_n || a_r) m_k = 0;
    else if (a_n)               m_k = m_k + 1;
    #1;
    reset = 0; pattern_reset = 0; pattern_next = 0; addr_reset = 0; addr_next = 0;
  endtask

  task automatic select_id(input int id);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < id; i++) step(0, 0, 1, 0, 0);
  endtask

  logic [15:0] rec [$];

  initial begin
    lfsr_tab[0] = 16'hACE1;
    for (int i = 1; i < 65535; i++)
      lfsr_tab[i] = {lfsr_tab[i-1][14:0],
                     lfsr_tab[i-1][15] ^ lfsr_tab[i-1][13] ^ lfsr_tab[i-1][12] ^ lfsr_tab[i-1][10]};

    // Reset state
    step(1, 0, 0, 0, 0);
    check("rst.id", 32'(pattern_id), 32'd0);
    check("rst.pat", 32'(pattern), 32'd0);
    check("rst.done", 32'(pattern_done), 32'd0);
    check("np1.rst.done", 32'(p1_done), 32'd1);
    check("np1.rst.id", 32'(p1_id), 32'd0);

    // Pattern list walk with saturation
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 0);
      check_model($sformatf("walk_ids[%0d]", i));
    end
    check("sat.id", 32'(pattern_id), 32'd7);
    check("np1.sat.done", 32'(p1_done), 32'd1);
    check("np1.sat.id", 32'(p1_id), 32'd0);
    select_id(2);
    check("id2.pat", 32'(pattern), 32'hAAAA);
    step(0, 0, 1, 0, 0);
    check("id3.pat", 32'(pattern), 32'h5555);

    // Walking one with rotation wrap
    select_id(4);
    step(0, 0, 0, 1, 0);
    check_model("walk.ar");
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 0, 0, 1);
      check_model($sformatf("walk[%0d]", i));
    end
    check("walk.wrap", 32'(pattern), 32'h0002);

    // LFSR seed, first step, reseed, write/read replay
    select_id(7);
    step(0, 0, 0, 1, 0);
    check("lfsr.seed", 32'(pattern), 32'hACE1);
    step(0, 0, 0, 0, 1);
    check("lfsr.step1", 32'(pattern), 32'h59C3);
    step(0, 0, 0, 1, 0);
    check("lfsr.reseed", 32'(pattern), 32'hACE1);
    rec.delete();
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 0, 1);
      rec.push_back(pattern);
      check_model($sformatf("wr[%0d]", i));
    end
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 0, 1);
      check($sformatf("rd[%0d]", i), 32'(pattern), 32'(rec[i]));
    end

    // Address as data, truncated and inverted
    addr = 20'hABCDE;
    select_id(5);
    check("addr.pat", 32'(pattern), 32'hBCDE);
    step(0, 0, 1, 0, 0);
    check("naddr.pat", 32'(pattern), 32'h4321);

    // Simultaneous events
    select_id(3);
    step(0, 1, 1, 0, 0);
    check("pr_pn.id", 32'(pattern_id), 32'd0);
    select_id(4);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    check("walk8.pat", 32'(pattern), 32'h0008);
    step(0, 0, 0, 1, 1);
    check("ar_an.pat", 32'(pattern), 32'h0001);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    check_model("pn_an");

    // Reset mid-operation
    select_id(7);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    check("midrst.id", 32'(pattern_id), 32'd0);
    check("midrst.pat", 32'(pattern), 32'd0);
    check("midrst.done", 32'(pattern_done), 32'd0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    check("midrst.lfsr", 32'(pattern), 32'hACE1);

    // Randomized strobes against the model
    for (int i = 0; i < 400; i++) begin
      addr = ADDR_BITS'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
      check_model($sformatf("rnd[%0d]", i));
      check($sformatf("rnd_np1[%0d]", i), 32'(p1_done), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_pattern_gen.md
Name: sram_pattern_gen

Overview:
- Data-pattern source for the SRAM self-test.
- Sits between the test controller and the SRAM write path / result checker.
- Supplies the word written at each address during the write pass, and regenerates the identical expected word during the read pass.
- Steps through an ordered pattern list on the controller's pattern_next/pattern_reset strobes and flags the last pattern with pattern_done.

Parameters:
- DATA_BITS, 16, SRAM data width (>=2).
- ADDR_BITS, 20, width of the address supplied by the address generator.
- NUM_PATTERNS, 8, number of patterns used, 1..8; the list is truncated from the top.
- LFSR_SEED, 16'hACE1, LFSR seed; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- pattern_reset  input  1  return to pattern 0 and reseed
- pattern_next  input  1  advance to next pattern and reseed
- addr_reset  input  1  same strobe that rewinds the address generator; reseeds per-address state
- addr_next  input  1  same strobe that advances the address generator; steps per-address state
- addr  input  ADDR_BITS  current address from the address generator
- pattern  output  DATA_BITS  data word for the current pattern/address
- pattern_done  output  1  high while the last pattern (NUM_PATTERNS-1) is selected
- pattern_id  output  3  current pattern index (debug)

Behaviour:
Pattern list by index:
- 0: all zeros.
- 1: all ones.
- 2: 0xAAAA... (bit0=0, alternating).
- 3: 0x5555... (bit0=1, alternating).
- 4: walking one (walk register).
- 5: address as data.
- 6: inverted address.
- 7: LFSR.

Internal registers (all update on the rising clk edge):
- pattern_id: 3 bits.
- walk: DATA_BITS bits.
- lfsr: 16 bits.

pattern_id update, in priority order:
- reset or pattern_reset: 0.
- pattern_next: +1, saturating at NUM_PATTERNS-1. No wrap; pattern_next at the last pattern leaves pattern_id unchanged.
- otherwise: hold.

walk / lfsr update, in priority order:
- reset, pattern_reset, pattern_next or addr_reset: walk = 1, lfsr = seed.
- addr_next: walk rotates left by 1 (MSB wraps to bit0); lfsr steps once.
- otherwise: hold.
- Per-address state updates regardless of the selected pattern.

LFSR step:
- Shift left by 1.
- New bit0 = b15 ^ b13 ^ b12 ^ b10.
- Period 65535; never reaches 0.

Output timing:
- pattern is combinational from pattern_id, walk, lfsr and addr.
- No added latency: pattern tracks addr in the same cycle, because walk/lfsr step on the same edge as the address generator.

Width rules:
- Index 5: addr zero-extended to DATA_BITS, or truncated to its low DATA_BITS.
- Index 6: bitwise inverse of the index-5 value.
- Index 7: the 16-bit lfsr replicated to fill DATA_BITS, low DATA_BITS taken.

pattern_done:
- Equals (pattern_id == NUM_PATTERNS-1), combinational.
- Held constant 1 when NUM_PATTERNS = 1.

Reset values:
- pattern_id = 0, pattern = 0, walk = 1, lfsr = seed.
- pattern_done = 1 only if NUM_PATTERNS = 1, else 0.

Reproducibility:
- An identical sequence of addr_next strobes following an addr_reset produces an identical pattern sequence. The write pass and read pass therefore compare equal on fault-free SRAM.

Simultaneous events:
- pattern_reset together with pattern_next: reset wins.
- addr_reset together with addr_next: reset wins (walk = 1, lfsr = seed).
- pattern_next together with addr_next: the reseed wins.

Reset mid-operation: the next edge restores all reset values regardless of pattern_id or walk/lfsr state.

Test Plan:
Defaults used: DATA_BITS=16, ADDR_BITS=20, NUM_PATTERNS=8.
1. Reset, then one pattern_next pulse per cycle, 8 pulses -> pattern_id 0..7; pattern = 0000, FFFF, AAAA, 5555 at ids 0-3; pattern_done first high at id 7; 8th pulse leaves id 7 and pattern_done high.
2. Select id 4, pulse addr_reset, then 17 addr_next pulses -> pattern 0001, 0002, 0004 … 8000, then 0001, 0002 (rotation wrap).
3. Select id 7, pulse addr_reset -> pattern ACE1; one addr_next -> 59C3; addr_reset again -> ACE1. A write-pass sequence of 100 steps must equal a replayed read-pass sequence word for word.
4. Drive addr = 0xABCDE -> id 5 gives pattern BCDE; id 6 gives 4321.
5. Simultaneous events:
   - pattern_reset and pattern_next in the same cycle at id 3 -> id 0.
   - At id 4, walk = 0x0008, addr_reset and addr_next together -> pattern 0001.
6. Reset mid-operation:
   - At id 7 with lfsr advanced, assert reset for one cycle -> next cycle id 0, pattern 0000, pattern_done 0.
   - Then select id 7 -> pattern ACE1 (lfsr reseeded).
   - NUM_PATTERNS=1 build: pattern_done=1 out of reset.
